// File: rtl/bcnt_capt.sv
// bcnt_capt: timestamp capture stage behind the fast binary counter.
//   Synchronizes an asynchronous event and detects the selected edge(s).
//   On each qualified edge it samples {epoch, cnt_q}. The epoch counts the
//   counter's overflow pulses.
//   Samples are queued in a first-word-fall-through FIFO. The FIFO is read
//   through a valid/ready handshake.
// Ports:
//   clk, sclr        clock, synchronous active-high reset
//   ena              capture enable (epoch tracks regardless)
//   evt              asynchronous event input
//   cnt_q, cnt_ovf   upstream counter value and one-cycle wrap pulse
//   m_data/m_valid   FIFO head {epoch, count} / non-empty
//   m_ready          consumer accept
//   level            FIFO occupancy 0..DEPTH
//   lost, lost_clr   sticky overflow-drop flag and its clear
module bcnt_capt #(
  parameter int WIDTH = 64,
  parameter int EPW   = 8,
  parameter int DEPTH = 8,
  parameter int SYNC  = 2,
  parameter int EDGE  = 0
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     ena,
  input  logic                     evt,
  input  logic [WIDTH-1:0]         cnt_q,
  input  logic                     cnt_ovf,
  output logic [EPW+WIDTH-1:0]     m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     lost,
  input  logic                     lost_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = EPW + WIDTH;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // synchronizer, edge history, post-reset edge mask
  logic [SYNC-1:0] sync;
  logic            hist;
  logic [SYNC:0]   msk_pipe;   // SYNC+1 ones shifted out after reset
  logic            mask, rise, fall, evt_edge;

  always_ff @(posedge clk) begin
    if (sclr) begin
      sync     <= '0;
      hist     <= 1'b0;
      msk_pipe <= '1;
    end else begin
      sync     <= {sync[SYNC-2:0], evt};
      hist     <= sync[SYNC-1];
      msk_pipe <= {msk_pipe[SYNC-1:0], 1'b0};
    end
  end

  assign mask     = |msk_pipe;
  assign rise     = sync[SYNC-1] & ~hist;
  assign fall     = ~sync[SYNC-1] & hist;
  assign evt_edge = (EDGE == 0) ? rise : (EDGE == 1) ? fall : (rise | fall);

  // epoch: the value present this cycle is captured, so a coincident
  // overflow lands in the next sample only
  logic [EPW-1:0] epoch;

  always_ff @(posedge clk) begin
    if (sclr)         epoch <= '0;
    else if (cnt_ovf) epoch <= epoch + 1'b1;
  end

  // FWFT FIFO
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, push, pop, push_ok, drop;

  assign full    = (level == FULL_LVL);
  assign m_valid = (level != '0);
  assign pop     = m_valid & m_ready;
  assign push    = evt_edge & ena & ~mask;
  assign push_ok = push & (~full | pop);  // a same-cycle pop frees the slot
  assign drop    = push & full & ~pop;
  assign m_data  = m_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= {epoch, cnt_q};
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // drop wins over a coincident clear
  always_ff @(posedge clk) begin
    if (sclr)          lost <= 1'b0;
    else if (drop)     lost <= 1'b1;
    else if (lost_clr) lost <= 1'b0;
  end

endmodule
